// File: rtl/ext_int_controller_pkg.sv
// Shared types, constants and helpers for the external interrupt controller.
package ext_int_controller_pkg;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  // Gray-coded so every legal transition flips one bit and the REQ decode cannot glitch.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SETUP = 2'b01,
    ST_REQ   = 2'b11,
    ST_GAP   = 2'b10
  } state_t;

  function automatic int calcIdW(input int numSrc);
    return (numSrc <= 2) ? 1 : $clog2(numSrc);
  endfunction

endpackage

// File: rtl/ext_int_controller_sync.sv
// Two-flop synchronizer for one asynchronous level into the Sys_Clock domain.
module ext_int_controller_sync (
  input  logic Sys_Clock,
  input  logic Sys_Reset,
  input  logic i_async,
  output logic o_sync
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge Sys_Clock or negedge Sys_Reset) begin
    if (!Sys_Reset) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule

// File: rtl/ext_int_controller.sv
// External interrupt controller: latches source edges, arbitrates by fixed priority and
// hands one ID at a time to the core with setup/gap timing and a toggle acknowledge.
module ext_int_controller
  import ext_int_controller_pkg::*;
#(
  parameter int NUM_SRC   = 2,
  parameter int ID_W      = calcIdW(NUM_SRC),
  parameter int SETUP_CYC = 3,
  parameter int GAP_CYC   = 3
) (
  input  logic                Sys_Clock,
  input  logic                Sys_Reset,
  input  logic [NUM_SRC-1:0]  Src_Irq,
  input  logic                Cfg_We,
  input  logic [NUM_SRC-1:0]  Cfg_Mask,
  input  logic                EIC_IntAck,
  output logic                EIC_IntReq,
  output logic [ID_W-1:0]     EIC_IntId,
  output logic [NUM_SRC-1:0]  Pending,
  output logic                Busy,
  output logic                Err_SpurAck
);

  localparam int MAX_CYC = (SETUP_CYC > GAP_CYC) ? SETUP_CYC : GAP_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;
  localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_CYC - 1);

  state_t             r_state;
  state_t             w_nextState;
  logic [CNT_W-1:0]   r_cnt;
  logic [ID_W-1:0]    r_curId;
  logic               r_reEdge;
  logic [NUM_SRC-1:0] w_srcSync;
  logic [NUM_SRC-1:0] r_srcLast;
  logic [NUM_SRC-1:0] w_srcEdge;
  logic [NUM_SRC-1:0] r_pending;
  logic [NUM_SRC-1:0] r_mask;
  logic [NUM_SRC-1:0] w_cand;
  logic [NUM_SRC-1:0] w_clr;
  logic               w_ackSync;
  logic               r_ackLast;
  logic               w_ackTgl;
  logic               w_ackAccept;
  logic               w_intReq;
  logic               w_busy;
  logic               w_spurAck;

  function automatic logic [ID_W-1:0] prioEnc(input logic [NUM_SRC-1:0] vec);
    logic [ID_W-1:0] result;
    result = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (vec[i]) result = ID_W'(i);
    end
    return result;
  endfunction

  for (genvar g = 0; g < NUM_SRC; g++) begin : gSrcSync
    ext_int_controller_sync uSrcSync (
      .Sys_Clock (Sys_Clock),
      .Sys_Reset (Sys_Reset),
      .i_async   (Src_Irq[g]),
      .o_sync    (w_srcSync[g])
    );
  end

  ext_int_controller_sync uAckSync (
    .Sys_Clock (Sys_Clock),
    .Sys_Reset (Sys_Reset),
    .i_async   (EIC_IntAck),
    .o_sync    (w_ackSync)
  );

  assign w_srcEdge   = w_srcSync & ~r_srcLast;
  assign w_ackTgl    = w_ackSync ^ r_ackLast;
  assign w_cand      = r_pending & r_mask;
  assign w_ackAccept = (r_state == ST_REQ) && w_ackTgl;
  // A re-edge of the presented source since selection keeps its pending bit alive.
  assign w_clr       = (w_ackAccept && !r_reEdge) ? (NUM_SRC'(1) << r_curId) : '0;

  always_ff @(posedge Sys_Clock or negedge Sys_Reset) begin
    if (!Sys_Reset) begin
      r_srcLast <= '0;
      r_ackLast <= 1'b0;
      r_pending <= '0;
      r_mask    <= '1;
    end else begin
      r_srcLast <= w_srcSync;
      r_ackLast <= w_ackSync;
      r_pending <= (r_pending & ~w_clr) | w_srcEdge;
      if (Cfg_We) r_mask <= Cfg_Mask;
    end
  end

  always_ff @(posedge Sys_Clock or negedge Sys_Reset) begin
    if (!Sys_Reset) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_curId  <= '0;
      r_reEdge <= 1'b0;
    end else begin
      r_state <= w_nextState;
      case (r_state)
        ST_IDLE: begin
          if (w_nextState == ST_SETUP) begin
            r_curId  <= prioEnc(w_cand);
            r_cnt    <= SETUP_LOAD;
            r_reEdge <= 1'b0;
          end
        end
        ST_SETUP: begin
          if (r_cnt != '0) r_cnt <= r_cnt - CNT_W'(1);
          if (w_srcEdge[r_curId]) r_reEdge <= 1'b1;
        end
        ST_REQ: begin
          if (w_ackAccept) r_cnt <= GAP_LOAD;
          if (w_srcEdge[r_curId]) r_reEdge <= 1'b1;
        end
        ST_GAP: begin
          if (r_cnt != '0) r_cnt <= r_cnt - CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE:  if (w_cand != '0) w_nextState = ST_SETUP;
      ST_SETUP: if (r_cnt == '0)  w_nextState = ST_REQ;
      ST_REQ:   if (w_ackTgl)     w_nextState = ST_GAP;
      ST_GAP:   if (r_cnt == '0)  w_nextState = ST_IDLE;
      default:  w_nextState = ST_IDLE;
    endcase
  end

  always_comb begin
    w_intReq  = FALSE;
    w_busy    = TRUE;
    w_spurAck = FALSE;
    case (r_state)
      ST_IDLE: begin
        w_busy    = FALSE;
        w_spurAck = w_ackTgl;
      end
      ST_SETUP, ST_GAP: w_spurAck = w_ackTgl;
      ST_REQ:           w_intReq  = TRUE;
      default: ;
    endcase
  end

  assign EIC_IntReq  = w_intReq;
  assign EIC_IntId   = r_curId;
  assign Pending     = r_pending;
  assign Busy        = w_busy;
  assign Err_SpurAck = w_spurAck;

endmodule
